vga_timing_gen: RTL and testbench

//   Source end of the pixel-scan interface: generates hcount/vcount/xcoord/ycoord/active for the

---
 rtl/vga_timing_gen_if.sv | 32 +++
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-scan interface between the VGA timing source and the drawing path / DAC pins.
// The master is the timing generator; the slave is the drawing path that supplies RGB.
interface vga_timing_gen_if;
    logic [7:0] vga_r_in;
    logic [7:0] vga_g_in;
    logic [7:0] vga_b_in;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] xcoord;
    logic [9:0] ycoord;
    logic       active;
    logic       frame_tick;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;

    modport master (
        input  vga_r_in, vga_g_in, vga_b_in,
        output hcount, vcount, xcoord, ycoord, active, frame_tick,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n
    );

    modport slave (
        output vga_r_in, vga_g_in, vga_b_in,
        input  hcount, vcount, xcoord, ycoord, active, frame_tick,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA scan timing generator: pixel counters, scan coordinates, frame tick and retimed DAC outputs.
// Define VGA_PIXEL_DIV_EN to advance one pixel every second clk (e.g. 50 MHz clk, 25 MHz pixel).
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       pe;
    logic       advanced;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       frame_tick_q;
    logic       active;
    logic       hsync_raw;
    logic       vsync_raw;
    logic [2:0] scan_raw;
    logic [2:0] scan_dly;
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;
    logic       hs_q;
    logic       vs_q;
    logic       blank_n_q;

`ifdef VGA_PIXEL_DIV_EN
    logic pe_toggle;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pe_toggle <= 1'b0;
        end else begin
            pe_toggle <= ~pe_toggle;
        end
    end

    assign pe = pe_toggle;
`else
    assign pe = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // 'advanced' marks the first clk of each pixel so the tick stays one clk wide when pe is divided.
    always_ff @(posedge clk) begin
        if (!reset) begin
            advanced     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            advanced     <= pe;
            frame_tick_q <= advanced && (h_cnt == '0) && (v_cnt == V_ACT);
        end
    end

    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync_raw = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vsync_raw = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    assign scan_raw  = {hsync_raw, vsync_raw, active};

    // The delay line runs on every clk so it matches the draw-path latency measured in clks.
    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign scan_dly = scan_raw;
        end else begin : g_pipe
            logic [2:0] stage [PIPE_DELAY];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= scan_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign scan_dly = stage[PIPE_DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            r_q       <= scan_dly[0] ? bus.vga_r_in : 8'h00;
            g_q       <= scan_dly[0] ? bus.vga_g_in : 8'h00;
            b_q       <= scan_dly[0] ? bus.vga_b_in : 8'h00;
            hs_q      <= ~scan_dly[2];
            vs_q      <= ~scan_dly[1];
            blank_n_q <= scan_dly[0];
        end
    end

    assign bus.hcount      = h_cnt;
    assign bus.vcount      = v_cnt;
    assign bus.xcoord      = (h_cnt < H_ACT) ? h_cnt : '0;
    assign bus.ycoord      = (v_cnt < V_ACT) ? v_cnt : '0;
    assign bus.active      = active;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.vga_r       = r_q;
    assign bus.vga_g       = g_q;
    assign bus.vga_b       = b_q;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.vga_sync_n  = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance (PIPE_DELAY=2) for line timing,
// and a tiny-raster instance (PIPE_DELAY=0) so whole frames, wraps and frame ticks fit in a short run.
module tb_vga_timing_gen;
    logic clk;
    logic reset_a;
    logic reset_b;

    int compared;
    int mismatched;

    int hs_low, hs_first, vs_low, vs_first;
    int blank_hi, blank_first, rgb_hits, rgb_leak, ticks, tick_first;

    vga_timing_gen_if a_if ();
    vga_timing_gen_if b_if ();

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .PIPE_DELAY(2)
    ) dut_a (
        .clk  (clk),
        .reset(reset_a),
        .bus  (a_if)
    );

    // Small raster: 25 clk per line (hsync 18..21), 15 lines per frame (vsync lines 10..11).
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIPE_DELAY(0)
    ) dut_b (
        .clk  (clk),
        .reset(reset_b),
        .bus  (b_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ar, input logic [7:0] ag, input logic [7:0] ab,
                                 input logic [7:0] br, input logic [7:0] bg, input logic [7:0] bb);
        a_if.vga_r_in = ar;
        a_if.vga_g_in = ag;
        a_if.vga_b_in = ab;
        b_if.vga_r_in = br;
        b_if.vga_g_in = bg;
        b_if.vga_b_in = bb;
    endtask

    task automatic clearTallies();
        hs_low = 0; hs_first = 0; vs_low = 0; vs_first = 0;
        blank_hi = 0; blank_first = 0; rgb_hits = 0; rgb_leak = 0;
        ticks = 0; tick_first = 0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_a    = 1'b0;
        reset_b    = 1'b0;
        applyStimulus(8'hFF, 8'h5A, 8'h3C, 8'h11, 8'h22, 8'h33);

        repeat (3) @(negedge clk);
        checkOutput("a_rst_hcount", int'(a_if.hcount), 0);
        checkOutput("a_rst_vcount", int'(a_if.vcount), 0);
        checkOutput("a_rst_xcoord", int'(a_if.xcoord), 0);
        checkOutput("a_rst_ycoord", int'(a_if.ycoord), 0);
        checkOutput("a_rst_active", int'(a_if.active), 1);
        checkOutput("a_rst_tick", int'(a_if.frame_tick), 0);
        checkOutput("a_rst_r", int'(a_if.vga_r), 0);
        checkOutput("a_rst_hs", int'(a_if.vga_hs), 1);
        checkOutput("a_rst_vs", int'(a_if.vga_vs), 1);
        checkOutput("a_rst_blank_n", int'(a_if.vga_blank_n), 0);
        checkOutput("a_sync_n", int'(a_if.vga_sync_n), 0);

        // Three full lines of the 640x480 raster; pins lag the counters by 3 clk.
        reset_a = 1'b1;
        clearTallies();
        for (int k = 1; k <= 2400; k++) begin
            @(negedge clk);
            if (!a_if.vga_hs) begin
                hs_low++;
                if (hs_first == 0) hs_first = k;
            end
            if (!a_if.vga_vs) vs_low++;
            if (a_if.vga_blank_n) begin
                blank_hi++;
                if (blank_first == 0) blank_first = k;
            end
            if (a_if.vga_r == 8'hFF && a_if.vga_g == 8'h5A && a_if.vga_b == 8'h3C) rgb_hits++;
            if (!a_if.vga_blank_n && (a_if.vga_r != 8'h00 || a_if.vga_g != 8'h00)) rgb_leak++;
            if (a_if.frame_tick) ticks++;
            if (k == 1) checkOutput("a_first_advance", int'(a_if.hcount), 1);
            if (k == 642) checkOutput("a_blank_last_px", int'(a_if.vga_blank_n), 1);
            if (k == 643) checkOutput("a_blank_after_640", int'(a_if.vga_blank_n), 0);
            if (k == 658) checkOutput("a_hs_before", int'(a_if.vga_hs), 1);
            if (k == 754) checkOutput("a_hs_last_low", int'(a_if.vga_hs), 0);
            if (k == 755) checkOutput("a_hs_release", int'(a_if.vga_hs), 1);
            if (k == 700) begin
                checkOutput("a_hcount_700", int'(a_if.hcount), 700);
                checkOutput("a_xcoord_porch", int'(a_if.xcoord), 0);
                checkOutput("a_active_porch", int'(a_if.active), 0);
            end
            if (k == 1000) begin
                checkOutput("a_hcount_l1", int'(a_if.hcount), 200);
                checkOutput("a_vcount_l1", int'(a_if.vcount), 1);
                checkOutput("a_xcoord_l1", int'(a_if.xcoord), 200);
                checkOutput("a_ycoord_l1", int'(a_if.ycoord), 1);
                checkOutput("a_active_l1", int'(a_if.active), 1);
            end
        end
        checkOutput("a_hs_low_clks", hs_low, 288);
        checkOutput("a_hs_first_low", hs_first, 659);
        checkOutput("a_vs_low_clks", vs_low, 0);
        checkOutput("a_blank_hi_clks", blank_hi, 1920);
        checkOutput("a_blank_first", blank_first, 3);
        checkOutput("a_rgb_hits", rgb_hits, 1920);
        checkOutput("a_rgb_leak", rgb_leak, 0);
        checkOutput("a_ticks", ticks, 0);

        // Mid-line reset at (300,3) for one clk, then rescan from (0,0).
        repeat (300) @(negedge clk);
        checkOutput("a_pre_rst_hcount", int'(a_if.hcount), 300);
        checkOutput("a_pre_rst_vcount", int'(a_if.vcount), 3);
        reset_a = 1'b0;
        @(negedge clk);
        checkOutput("a_mid_rst_hcount", int'(a_if.hcount), 0);
        checkOutput("a_mid_rst_vcount", int'(a_if.vcount), 0);
        checkOutput("a_mid_rst_r", int'(a_if.vga_r), 0);
        checkOutput("a_mid_rst_hs", int'(a_if.vga_hs), 1);
        checkOutput("a_mid_rst_vs", int'(a_if.vga_vs), 1);
        checkOutput("a_mid_rst_blank_n", int'(a_if.vga_blank_n), 0);
        reset_a = 1'b1;
        @(negedge clk);
        checkOutput("a_resume_hcount", int'(a_if.hcount), 1);
        @(negedge clk);
        checkOutput("a_resume_pipe_clear", int'(a_if.vga_blank_n), 0);
        @(negedge clk);
        checkOutput("a_resume_blank_n", int'(a_if.vga_blank_n), 1);
        checkOutput("a_resume_r", int'(a_if.vga_r), 255);

        // Small raster: two full frames plus two lines; pins lag the counters by 1 clk.
        checkOutput("b_rst_blank_n", int'(b_if.vga_blank_n), 0);
        checkOutput("b_sync_n", int'(b_if.vga_sync_n), 0);
        reset_b = 1'b1;
        clearTallies();
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (!b_if.vga_hs) begin
                hs_low++;
                if (hs_first == 0) hs_first = k;
            end
            if (!b_if.vga_vs) begin
                vs_low++;
                if (vs_first == 0) vs_first = k;
            end
            if (b_if.vga_blank_n) blank_hi++;
            if (b_if.vga_r == 8'h11 && b_if.vga_g == 8'h22 && b_if.vga_b == 8'h33) rgb_hits++;
            if (!b_if.vga_blank_n && (b_if.vga_r != 8'h00 || b_if.vga_b != 8'h00)) rgb_leak++;
            if (b_if.frame_tick) begin
                ticks++;
                if (tick_first == 0) tick_first = k;
            end
            if (k == 60) begin
                checkOutput("b_xcoord_60", int'(b_if.xcoord), 10);
                checkOutput("b_ycoord_60", int'(b_if.ycoord), 2);
            end
            if (k == 70) begin
                checkOutput("b_xcoord_porch", int'(b_if.xcoord), 0);
                checkOutput("b_active_porch", int'(b_if.active), 0);
            end
            if (k == 230) begin
                checkOutput("b_xcoord_vblank", int'(b_if.xcoord), 5);
                checkOutput("b_ycoord_vblank", int'(b_if.ycoord), 0);
                checkOutput("b_active_vblank", int'(b_if.active), 0);
            end
            if (k == 200) checkOutput("b_tick_not_yet", int'(b_if.frame_tick), 0);
            if (k == 201) begin
                checkOutput("b_tick_vcount", int'(b_if.vcount), 8);
                checkOutput("b_tick_hcount", int'(b_if.hcount), 1);
            end
            if (k == 374) begin
                checkOutput("b_last_hcount", int'(b_if.hcount), 24);
                checkOutput("b_last_vcount", int'(b_if.vcount), 14);
            end
            if (k == 375) begin
                checkOutput("b_wrap_hcount", int'(b_if.hcount), 0);
                checkOutput("b_wrap_vcount", int'(b_if.vcount), 0);
                checkOutput("b_wrap_xcoord", int'(b_if.xcoord), 0);
                checkOutput("b_wrap_ycoord", int'(b_if.ycoord), 0);
                checkOutput("b_wrap_active", int'(b_if.active), 1);
                checkOutput("b_wrap_tick", int'(b_if.frame_tick), 0);
            end
        end
        checkOutput("b_hs_low_clks", hs_low, 128);
        checkOutput("b_hs_first_low", hs_first, 19);
        checkOutput("b_vs_low_clks", vs_low, 100);
        checkOutput("b_vs_first_low", vs_first, 251);
        checkOutput("b_blank_hi_clks", blank_hi, 288);
        checkOutput("b_rgb_hits", rgb_hits, 288);
        checkOutput("b_rgb_leak", rgb_leak, 0);
        checkOutput("b_ticks", ticks, 2);
        checkOutput("b_tick_first", tick_first, 201);

        // Mid-frame reset at (12,5) for one clk.
        repeat (87) @(negedge clk);
        checkOutput("b_pre_rst_hcount", int'(b_if.hcount), 12);
        checkOutput("b_pre_rst_vcount", int'(b_if.vcount), 5);
        checkOutput("b_pre_rst_blank_n", int'(b_if.vga_blank_n), 1);
        reset_b = 1'b0;
        @(negedge clk);
        checkOutput("b_mid_rst_hcount", int'(b_if.hcount), 0);
        checkOutput("b_mid_rst_vcount", int'(b_if.vcount), 0);
        checkOutput("b_mid_rst_active", int'(b_if.active), 1);
        checkOutput("b_mid_rst_r", int'(b_if.vga_r), 0);
        checkOutput("b_mid_rst_hs", int'(b_if.vga_hs), 1);
        checkOutput("b_mid_rst_vs", int'(b_if.vga_vs), 1);
        checkOutput("b_mid_rst_blank_n", int'(b_if.vga_blank_n), 0);
        checkOutput("b_mid_rst_tick", int'(b_if.frame_tick), 0);
        reset_b = 1'b1;
        @(negedge clk);
        checkOutput("b_resume_hcount", int'(b_if.hcount), 1);
        checkOutput("b_resume_xcoord", int'(b_if.xcoord), 1);
        checkOutput("b_resume_blank_n", int'(b_if.vga_blank_n), 1);
        checkOutput("b_resume_r", int'(b_if.vga_r), 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
